// File: rtl/matrix_mult_mac_pipe_pkg.sv
// Shared types and helpers for the matrix_mult MAC engine.
// Saturation limits are used only when the build defines MAC_SAT_EN.
package matrix_mult_pkg;

    // Accumulator FSM: waiting for the first term, or summing a dot product
    typedef enum logic [0:0] {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

    // Working width of the saturation helpers; callers truncate to ACC_WIDTH
    localparam int SAT_W = 64;

    // Largest representable accumulator value
    function automatic logic [SAT_W-1:0] sat_max(input int acc_width, input bit is_signed);
        logic [SAT_W-1:0] one_v;
        one_v = 64'd1;
        if (is_signed) begin
            return (one_v << (acc_width - 1)) - 64'd1;
        end else if (acc_width >= SAT_W) begin
            return {SAT_W{1'b1}};
        end else begin
            return (one_v << acc_width) - 64'd1;
        end
    endfunction

    // Smallest representable accumulator value (low ACC_WIDTH bits are meaningful)
    function automatic logic [SAT_W-1:0] sat_min(input int acc_width, input bit is_signed);
        logic [SAT_W-1:0] one_v;
        one_v = 64'd1;
        if (is_signed) begin
            return ~((one_v << (acc_width - 1)) - 64'd1);
        end else begin
            return 64'd0;
        end
    endfunction

endpackage

// File: rtl/matrix_mult_mac_pipe_if.sv
// Operand/result stream bundle for the matrix_mult MAC engine.
interface matrix_mult_mac_pipe_if #(
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] in_a;
    logic [DIN1_WIDTH-1:0] in_b;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_data;
    logic [CNT_WIDTH-1:0]  out_len;
    logic                  out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_len, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_len, out_ovf
    );
endinterface

// File: rtl/matrix_mult_mac_pipe_mul_pipe.sv
// NUM_STAGE-deep multiplier; valid and last travel with each product.
// The product is formed ahead of the first register; the remaining stages delay it.
module matrix_mult_mul_pipe #(
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 8,
    parameter int NUM_STAGE  = 2,
    parameter int SIGNED     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ce,
    input  logic                             in_valid,
    input  logic                             in_last,
    input  logic [DIN0_WIDTH-1:0]            in_a,
    input  logic [DIN1_WIDTH-1:0]            in_b,
    output logic                             p_valid,
    output logic                             p_last,
    output logic [DIN0_WIDTH+DIN1_WIDTH-1:0] p_data
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    logic [PW-1:0]        prod_s;
    logic [NUM_STAGE-1:0] vld_r;
    logic [NUM_STAGE-1:0] lst_r;
    logic [PW-1:0]        prd_r [NUM_STAGE];

    // Full-width product, operands extended according to the signedness mode
    always_comb begin
        if (SIGNED != 0) begin
            prod_s = $signed({{DIN1_WIDTH{in_a[DIN0_WIDTH-1]}}, in_a}) *
                     $signed({{DIN0_WIDTH{in_b[DIN1_WIDTH-1]}}, in_b});
        end else begin
            prod_s = {{DIN1_WIDTH{1'b0}}, in_a} * {{DIN0_WIDTH{1'b0}}, in_b};
        end
    end

    // Pipeline shift; everything freezes while ce is low
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= '0;
            lst_r <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                prd_r[i] <= '0;
            end
        end else if (ce) begin
            vld_r[0] <= in_valid;
            lst_r[0] <= in_valid & in_last;
            prd_r[0] <= prod_s;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_r[i] <= vld_r[i-1];
                lst_r[i] <= lst_r[i-1];
                prd_r[i] <= prd_r[i-1];
            end
        end
    end

    assign p_valid = vld_r[NUM_STAGE-1];
    assign p_last  = lst_r[NUM_STAGE-1];
    assign p_data  = prd_r[NUM_STAGE-1];
endmodule

// File: rtl/matrix_mult_mac_pipe.sv
// Pipelined multiply-accumulate engine for matrix_mult dot products.
// One term per beat, in_last closes a dot product, one result word per dot product.
// Optional build macro MAC_SAT_EN: saturating accumulator with a sticky overflow flag;
// without it the sum wraps and out_ovf stays 0.
module matrix_mult_mac_pipe
    import matrix_mult_pkg::*;
#(
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int NUM_STAGE  = 2,
    parameter int SIGNED     = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    matrix_mult_mac_pipe_if.slave  mac
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    acc_state_t           state_r, state_nxt_s;
    logic [ACC_WIDTH-1:0] acc_r, acc_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_nxt_s;
    logic                 ovf_r, ovf_nxt_s;
    logic                 rdy_en_r;
    logic                 out_valid_r, out_valid_nxt_s;
    logic [ACC_WIDTH-1:0] out_data_r, out_data_nxt_s;
    logic [CNT_WIDTH-1:0] out_len_r, out_len_nxt_s;
    logic                 out_ovf_r, out_ovf_nxt_s;

    logic                 stall_s;
    logic                 ce_s;
    logic                 beat_s;
    logic                 p_valid_s;
    logic                 p_last_s;
    logic [PW-1:0]        p_data_s;
    logic [ACC_WIDTH-1:0] ext_s;
    logic [ACC_WIDTH-1:0] base_s;
    logic [CNT_WIDTH-1:0] cnt_inc_s;
    logic                 ovf_prev_s;
    logic [ACC_WIDTH-1:0] sum_s;
    logic                 ovf_hit_s;

`ifdef MAC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED != 0));
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, SIGNED != 0));
    logic [ACC_WIDTH:0] wide_s;
`endif

    assign stall_s   = out_valid_r & ~mac.out_ready;
    assign ce_s      = ~stall_s;
    assign mac.in_ready = rdy_en_r & ~stall_s;
    assign beat_s    = mac.in_valid & mac.in_ready;

    matrix_mult_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .NUM_STAGE  (NUM_STAGE),
        .SIGNED     (SIGNED)
    ) u_mul (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .ce       (ce_s),
        .in_valid (beat_s),
        .in_last  (mac.in_last),
        .in_a     (mac.in_a),
        .in_b     (mac.in_b),
        .p_valid  (p_valid_s),
        .p_last   (p_last_s),
        .p_data   (p_data_s)
    );

    // Widen the product to the accumulator width, sign- or zero-extended
    always_comb begin
        if (SIGNED != 0) begin
            ext_s = ACC_WIDTH'($signed(p_data_s));
        end else begin
            ext_s = ACC_WIDTH'(p_data_s);
        end
    end

    // Starting point for this term: a fresh dot product restarts sum, count and flag
    always_comb begin
        case (state_r)
            ACC_RUN: begin
                base_s     = acc_r;
                cnt_inc_s  = (&cnt_r) ? cnt_r : cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                ovf_prev_s = ovf_r;
            end
            ACC_IDLE: begin
                base_s     = '0;
                cnt_inc_s  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                ovf_prev_s = 1'b0;
            end
            default: begin
                base_s     = '0;
                cnt_inc_s  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                ovf_prev_s = 1'b0;
            end
        endcase
    end

`ifdef MAC_SAT_EN
    // Saturating add: clamp to the range limit in the direction of the overflow
    always_comb begin
        if (SIGNED != 0) begin
            wide_s = {base_s[ACC_WIDTH-1], base_s} + {ext_s[ACC_WIDTH-1], ext_s};
            if (wide_s[ACC_WIDTH] != wide_s[ACC_WIDTH-1]) begin
                ovf_hit_s = 1'b1;
                if (wide_s[ACC_WIDTH]) begin
                    sum_s = SAT_MIN;
                end else begin
                    sum_s = SAT_MAX;
                end
            end else begin
                ovf_hit_s = 1'b0;
                sum_s     = wide_s[ACC_WIDTH-1:0];
            end
        end else begin
            wide_s = {1'b0, base_s} + {1'b0, ext_s};
            if (wide_s[ACC_WIDTH]) begin
                ovf_hit_s = 1'b1;
                sum_s     = SAT_MAX;
            end else begin
                ovf_hit_s = 1'b0;
                sum_s     = wide_s[ACC_WIDTH-1:0];
            end
        end
    end
`else
    // Wrapping add modulo 2^ACC_WIDTH; overflow is never flagged
    always_comb begin
        sum_s     = base_s + ext_s;
        ovf_hit_s = 1'b0;
    end
`endif

    // Accumulator FSM next state and result register update
    always_comb begin
        state_nxt_s    = state_r;
        acc_nxt_s      = acc_r;
        cnt_nxt_s      = cnt_r;
        ovf_nxt_s      = ovf_r;
        out_data_nxt_s = out_data_r;
        out_len_nxt_s  = out_len_r;
        out_ovf_nxt_s  = out_ovf_r;
        if (mac.out_ready) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
        if (ce_s && p_valid_s) begin
            if (p_last_s) begin
                out_data_nxt_s  = sum_s;
                out_len_nxt_s   = cnt_inc_s;
                out_ovf_nxt_s   = ovf_prev_s | ovf_hit_s;
                out_valid_nxt_s = 1'b1;
                state_nxt_s     = ACC_IDLE;
                acc_nxt_s       = '0;
                cnt_nxt_s       = '0;
                ovf_nxt_s       = 1'b0;
            end else begin
                state_nxt_s = ACC_RUN;
                acc_nxt_s   = sum_s;
                cnt_nxt_s   = cnt_inc_s;
                ovf_nxt_s   = ovf_prev_s | ovf_hit_s;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r <= ACC_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Accumulator, counter, flag and output registers; in_ready enable follows reset by a cycle
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_r       <= '0;
            cnt_r       <= '0;
            ovf_r       <= 1'b0;
            rdy_en_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_len_r   <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ovf_r       <= ovf_nxt_s;
            rdy_en_r    <= 1'b1;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_len_r   <= out_len_nxt_s;
            out_ovf_r   <= out_ovf_nxt_s;
        end
    end

    assign mac.out_valid = out_valid_r;
    assign mac.out_data  = out_data_r;
    assign mac.out_len   = out_len_r;
    assign mac.out_ovf   = out_ovf_r;
endmodule

// File: tb/tb_matrix_mult_mac_pipe.sv
// Self-checking bench for matrix_mult_mac_pipe: three instances (signed 24-bit,
// signed 16-bit, unsigned 24-bit) share one stimulus driver; sel picks the active one.
module tb_matrix_mult_mac_pipe;
    localparam int STAGES = 2;

    logic ap_clk = 1'b0;
    logic ap_rst;
    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;
    int sel    = 0;

    logic       drv_valid, drv_last, man_ready, rnd_ready, rnd_bit, drv_out_ready;
    logic [7:0] drv_a, drv_b;

    logic        obs_valid, obs_in_ready, obs_ovf;
    logic [23:0] obs_data;
    logic [7:0]  obs_len;

    matrix_mult_mac_pipe_if #(.ACC_WIDTH(24)) if0 ();
    matrix_mult_mac_pipe_if #(.ACC_WIDTH(16)) if1 ();
    matrix_mult_mac_pipe_if #(.ACC_WIDTH(24)) if2 ();

    assign drv_out_ready = rnd_ready ? rnd_bit : man_ready;

    assign if0.in_valid = drv_valid & (sel == 0);
    assign if1.in_valid = drv_valid & (sel == 1);
    assign if2.in_valid = drv_valid & (sel == 2);
    assign if0.in_a = drv_a;  assign if1.in_a = drv_a;  assign if2.in_a = drv_a;
    assign if0.in_b = drv_b;  assign if1.in_b = drv_b;  assign if2.in_b = drv_b;
    assign if0.in_last = drv_last;  assign if1.in_last = drv_last;  assign if2.in_last = drv_last;
    assign if0.out_ready = drv_out_ready;
    assign if1.out_ready = drv_out_ready;
    assign if2.out_ready = drv_out_ready;

    matrix_mult_mac_pipe #(.ACC_WIDTH(24), .NUM_STAGE(STAGES), .SIGNED(1)) dut0 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .mac(if0.slave));
    matrix_mult_mac_pipe #(.ACC_WIDTH(16), .NUM_STAGE(STAGES), .SIGNED(1)) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .mac(if1.slave));
    matrix_mult_mac_pipe #(.ACC_WIDTH(24), .NUM_STAGE(STAGES), .SIGNED(0)) dut2 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .mac(if2.slave));

    always_comb begin
        case (sel)
            1: begin
                obs_valid = if1.out_valid; obs_in_ready = if1.in_ready;
                obs_data = {8'h00, if1.out_data}; obs_len = if1.out_len; obs_ovf = if1.out_ovf;
            end
            2: begin
                obs_valid = if2.out_valid; obs_in_ready = if2.in_ready;
                obs_data = if2.out_data; obs_len = if2.out_len; obs_ovf = if2.out_ovf;
            end
            default: begin
                obs_valid = if0.out_valid; obs_in_ready = if0.in_ready;
                obs_data = if0.out_data; obs_len = if0.out_len; obs_ovf = if0.out_ovf;
            end
        endcase
    end

    typedef struct packed {
        logic [23:0] d;
        logic [7:0]  l;
        logic        o;
    } res_t;

    res_t got_q[$];
    res_t exp_q[$];

    // Random out_ready source used during the randomized phase
    always @(posedge ap_clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    // Result collector: records every completed output handshake
    always @(negedge ap_clk) begin
        if (obs_valid && drv_out_ready && !ap_rst) begin
            got_q.push_back(res_t'{d: obs_data, l: obs_len, o: obs_ovf});
        end
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Behavioural reference: plain integer dot product, then clamp or wrap to the width
    task automatic model_dot(input int s, input int n, input logic [7:0] av[8],
                             input logic [7:0] bv[8], output res_t r);
        int     w;
        bit     sg;
        longint one, acc, hi, lo, p;
        w  = (s == 1) ? 16 : 24;
        sg = (s != 2);
        one = 1;
        acc = 0;
        hi = sg ? (one << (w - 1)) - 1 : (one << w) - 1;
        lo = sg ? -(one << (w - 1)) : 0;
        r.o = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (sg) p = longint'($signed(av[i])) * longint'($signed(bv[i]));
            else    p = longint'(av[i]) * longint'(bv[i]);
            acc = acc + p;
`ifdef MAC_SAT_EN
            if (acc > hi) begin acc = hi; r.o = 1'b1; end
            else if (acc < lo) begin acc = lo; r.o = 1'b1; end
`endif
        end
        r.d = 24'(acc & ((one << w) - 1));
        r.l = 8'(n);
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        int guard;
        guard = 0;
        drv_valid = 1'b1; drv_a = a; drv_b = b; drv_last = last;
        @(negedge ap_clk);
        while (!obs_in_ready && guard < 200) begin
            @(negedge ap_clk);
            guard++;
        end
        if (!obs_in_ready) begin
            checks++; errors++;
            $display("FAIL beat_accept: in_ready stuck at 0, required 1 within 200 cycles");
        end
        @(posedge ap_clk);
        #1;
        drv_valid = 1'b0; drv_last = 1'b0;
    endtask

    task automatic send_dot(input int n, input logic [7:0] av[8], input logic [7:0] bv[8],
                            input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge ap_clk);
                #1;
            end
            send_beat(av[i], bv[i], i == n - 1);
        end
    endtask

    task automatic expect_result(input string name, input res_t e);
        int   guard;
        res_t r;
        guard = 0;
        while (got_q.size() == 0 && guard < 100) begin
            @(posedge ap_clk);
            guard++;
        end
        if (got_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no result, expected data 0x%0h", name, e.d);
        end else begin
            r = got_q.pop_front();
            chk({name, "_data"}, 32'(r.d), 32'(e.d));
            chk({name, "_len"},  32'(r.l), 32'(e.l));
            chk({name, "_ovf"},  32'(r.o), 32'(e.o));
        end
    endtask

    typedef struct packed {
        logic [1:0]      sel;
        logic [3:0]      n;
        logic [7:0][7:0] a;
        logic [7:0][7:0] b;
        logic [23:0]     d;
        logic [7:0]      l;
        logic            o;
    } vec_t;

    vec_t       vt[5];
    logic [7:0] av[8];
    logic [7:0] bv[8];
    res_t       er;
    int         lat;
    int         guard;

    initial begin
        // Directed table: sel, terms, expected result
        for (int i = 0; i < 5; i++) vt[i] = '0;
        vt[0].sel = 2'd0; vt[0].n = 4'd3;
        vt[0].a[0] = 8'd3;  vt[0].b[0] = 8'd4;
        vt[0].a[1] = 8'hFE; vt[0].b[1] = 8'd5;
        vt[0].a[2] = 8'd7;  vt[0].b[2] = 8'hFF;
        vt[0].d = 24'hFFFFFB; vt[0].l = 8'd3; vt[0].o = 1'b0;
        vt[1].sel = 2'd0; vt[1].n = 4'd1;
        vt[1].a[0] = 8'h80; vt[1].b[0] = 8'h80;
        vt[1].d = 24'd16384; vt[1].l = 8'd1; vt[1].o = 1'b0;
        vt[2].sel = 2'd1; vt[2].n = 4'd8;
        for (int i = 0; i < 8; i++) begin vt[2].a[i] = 8'd127; vt[2].b[i] = 8'd127; end
`ifdef MAC_SAT_EN
        vt[2].d = 24'h007FFF; vt[2].o = 1'b1;
`else
        vt[2].d = 24'h00F808; vt[2].o = 1'b0;
`endif
        vt[2].l = 8'd8;
        vt[3].sel = 2'd2; vt[3].n = 4'd2;
        vt[3].a[0] = 8'd255; vt[3].b[0] = 8'd255;
        vt[3].a[1] = 8'd255; vt[3].b[1] = 8'd255;
        vt[3].d = 24'd130050; vt[3].l = 8'd2; vt[3].o = 1'b0;
        vt[4].sel = 2'd0; vt[4].n = 4'd2;
        vt[4].a[0] = 8'h80; vt[4].b[0] = 8'd127;
        vt[4].a[1] = 8'h80; vt[4].b[1] = 8'd127;
        vt[4].d = 24'hFF8100; vt[4].l = 8'd2; vt[4].o = 1'b0;

        ap_rst = 1'b1; drv_valid = 1'b0; drv_last = 1'b0; drv_a = 8'd0; drv_b = 8'd0;
        man_ready = 1'b1; rnd_ready = 1'b0; rnd_bit = 1'b0;

        // Reset state
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_out_valid", 32'(obs_valid), 32'd0);
        chk("rst_out_data", 32'(obs_data), 32'd0);
        chk("rst_out_len", 32'(obs_len), 32'd0);
        chk("rst_out_ovf", 32'(obs_ovf), 32'd0);
        chk("rst_in_ready", 32'(obs_in_ready), 32'd0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_in_ready_hold", 32'(obs_in_ready), 32'd0);
        @(negedge ap_clk);
        chk("rst_in_ready_up", 32'(obs_in_ready), 32'd1);
        @(posedge ap_clk);
        #1;

        // Three-term signed dot product with latency measurement
        send_beat(8'd3, 8'd4, 1'b0);
        send_beat(8'hFE, 8'd5, 1'b0);
        send_beat(8'd7, 8'hFF, 1'b1);
        lat = 0;
        do begin
            @(negedge ap_clk);
            lat++;
        end while (!obs_valid && lat < 20);
        chk("t1_latency", 32'(lat), 32'(STAGES + 1));
        expect_result("t1", res_t'{d: 24'hFFFFFB, l: 8'd3, o: 1'b0});

        // Directed table
        for (int i = 0; i < 5; i++) begin
            @(posedge ap_clk);
            #1 sel = int'(vt[i].sel);
            for (int k = 0; k < 8; k++) begin av[k] = vt[i].a[k]; bv[k] = vt[i].b[k]; end
            send_dot(int'(vt[i].n), av, bv, 1'b0);
            expect_result($sformatf("vec%0d", i), res_t'{d: vt[i].d, l: vt[i].l, o: vt[i].o});
        end

        // Back-to-back dot products against a stalled consumer
        @(posedge ap_clk);
        #1 sel = 0; man_ready = 1'b0;
        fork
            begin
                av[0] = 8'd1; bv[0] = 8'd2; av[1] = 8'd3; bv[1] = 8'd4;
                send_dot(2, av, bv, 1'b0);
                av[0] = 8'd5;  bv[0] = 8'd6;  av[1] = 8'hFF; bv[1] = 8'd7;
                av[2] = 8'd2;  bv[2] = 8'd2;  av[3] = 8'd10; bv[3] = 8'hF6;
                av[4] = 8'd3;  bv[4] = 8'd3;
                send_dot(5, av, bv, 1'b0);
            end
            begin
                guard = 0;
                @(negedge ap_clk);
                while (!obs_valid && guard < 50) begin @(negedge ap_clk); guard++; end
                chk("bp_first_valid", 32'(obs_valid), 32'd1);
                for (int k = 0; k < 5; k++) begin
                    chk("bp_in_ready", 32'(obs_in_ready), 32'd0);
                    chk("bp_hold_data", 32'(obs_data), 32'd14);
                    @(negedge ap_clk);
                end
                @(posedge ap_clk);
                #1 man_ready = 1'b1;
            end
        join
        expect_result("bp_a", res_t'{d: 24'd14, l: 8'd2, o: 1'b0});
        expect_result("bp_b", res_t'{d: 24'hFFFFC0, l: 8'd5, o: 1'b0});

        // Reset in the middle of a dot product discards the partial sum
        send_beat(8'd9, 8'd9, 1'b0);
        send_beat(8'd9, 8'd9, 1'b0);
        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        send_beat(8'd2, 8'd3, 1'b1);
        expect_result("rst_mid", res_t'{d: 24'd6, l: 8'd1, o: 1'b0});
        repeat (10) @(posedge ap_clk);
        chk("rst_no_stray", 32'(got_q.size()), 32'd0);
        #1;

        // Randomized dot products per configuration with random backpressure
        rnd_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int k = 0; k < 10; k++) begin
                int n;
                n = $urandom_range(1, 8);
                for (int i = 0; i < 8; i++) begin
                    av[i] = 8'($urandom_range(0, 255));
                    bv[i] = 8'($urandom_range(0, 255));
                end
                model_dot(s, n, av, bv, er);
                exp_q.push_back(er);
                send_dot(n, av, bv, 1'b1);
            end
            while (exp_q.size() > 0) begin
                er = exp_q.pop_front();
                expect_result($sformatf("rand_sel%0d", s), er);
            end
            @(posedge ap_clk);
            #1;
        end
        rnd_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
